// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser slice.
package vend_pkg;
   localparam int MAX_NICKELS = 4;
   localparam int CHANGE_W    = 3;

   typedef enum logic [2:0] {IDLE, VEND, NICKEL, GAP, FAULT} state_e;

   // Codes above MAX_NICKELS come from a corrupted upstream FSM and must not vend.
   function automatic logic code_ok(input logic [CHANGE_W-1:0] code);
      return code <= CHANGE_W'(MAX_NICKELS);
   endfunction
endpackage

// File: rtl/vend_dispenser_if.sv
// Signal bundle between the dispenser, the vending FSM and the coin hopper.
// Optional counter ports exist only when VEND_DISPENSER_STATS_EN is defined.
interface vend_dispenser_if;
   import vend_pkg::*;

   logic                soda_i;
   logic [CHANGE_W-1:0] change_i;
   logic                hopper_ack_i;
   logic                fault_clr_i;
   logic                soda_sol_o;
   logic                hopper_req_o;
   logic                busy_o;
   logic                done_o;
   logic                fault_o;
   logic                overflow_o;
   logic [CHANGE_W-1:0] nickels_left_o;
`ifdef VEND_DISPENSER_STATS_EN
   logic [15:0]         vend_count_o;
   logic [15:0]         nickel_count_o;
`endif

   modport master (
      output soda_i, change_i, hopper_ack_i, fault_clr_i,
      input  soda_sol_o, hopper_req_o, busy_o, done_o, fault_o, overflow_o,
             nickels_left_o
`ifdef VEND_DISPENSER_STATS_EN
      , input vend_count_o, nickel_count_o
`endif
   );

   modport slave (
      input  soda_i, change_i, hopper_ack_i, fault_clr_i,
      output soda_sol_o, hopper_req_o, busy_o, done_o, fault_o, overflow_o,
             nickels_left_o
`ifdef VEND_DISPENSER_STATS_EN
      , output vend_count_o, nickel_count_o
`endif
   );
endinterface

// File: rtl/vend_timer.sv
// Loadable up/down cycle counter; tc flags 0 when counting down, TERM when counting up.
module vend_timer #(
   parameter int          W    = 5,
   parameter int unsigned TERM = 0
) (
   input  logic         clk_i,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         up,
   output logic         tc
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n)  cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en)   cnt <= up ? cnt + W'(1) : cnt - W'(1);
   end

   assign tc = up ? (cnt == W'(TERM)) : (cnt == '0);
endmodule

// File: rtl/vend_dispenser.sv
// Soda solenoid pulse plus nickel-by-nickel change dispensing with a one-deep pending slot.
// Define VEND_DISPENSER_STATS_EN to add saturating vend/nickel counters.
module vend_dispenser
   import vend_pkg::*;
#(
   parameter int SODA_PULSE_CYC     = 4,
   parameter int NICKEL_TIMEOUT_CYC = 16
) (
   input logic             clk_i,
   input logic             reset_n,
   vend_dispenser_if.slave bus
);
   localparam int TIMER_MAX = (SODA_PULSE_CYC > NICKEL_TIMEOUT_CYC) ? SODA_PULSE_CYC
                                                                    : NICKEL_TIMEOUT_CYC;
   localparam int TIMER_W   = $clog2(TIMER_MAX) + 1;

   state_e              state_q, state_d;
   logic [CHANGE_W-1:0] nick_q, nick_d, nick_dec;
   logic                pend_vld_q, pend_vld_d;
   logic [CHANGE_W-1:0] pend_code_q, pend_code_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic                src_vld;
   logic [CHANGE_W-1:0] src_code;
   logic                soda_load, soda_en, soda_tc;
   logic                hop_load, hop_en, hop_tc;
   logic                nick_acc;

   vend_timer #(.W(TIMER_W), .TERM(0)) u_soda_timer (
      .clk_i    (clk_i),
      .reset_n  (reset_n),
      .load     (soda_load),
      .load_val (TIMER_W'(SODA_PULSE_CYC - 1)),
      .en       (soda_en),
      .up       (1'b0),
      .tc       (soda_tc)
   );

   vend_timer #(.W(TIMER_W), .TERM(NICKEL_TIMEOUT_CYC - 1)) u_hop_timer (
      .clk_i    (clk_i),
      .reset_n  (reset_n),
      .load     (hop_load),
      .load_val ('0),
      .en       (hop_en),
      .up       (1'b1),
      .tc       (hop_tc)
   );

   always_comb begin
      state_d     = state_q;
      nick_d      = nick_q;
      pend_vld_d  = pend_vld_q;
      pend_code_d = pend_code_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      soda_load   = 1'b0;
      soda_en     = 1'b0;
      hop_load    = 1'b0;
      hop_en      = 1'b0;
      nick_acc    = 1'b0;
      nick_dec    = nick_q - CHANGE_W'(1);
      src_vld     = pend_vld_q | bus.soda_i;
      src_code    = pend_vld_q ? pend_code_q : bus.change_i;

      if (bus.fault_clr_i) ovf_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (src_vld) begin
               // Consuming the slot lets a same-cycle strobe take its place.
               if (pend_vld_q) begin
                  pend_vld_d  = bus.soda_i;
                  pend_code_d = bus.change_i;
               end
               if (code_ok(src_code)) begin
                  nick_d    = src_code;
                  soda_load = 1'b1;
                  state_d   = VEND;
               end else begin
                  state_d = FAULT;
               end
            end
         end
         VEND: begin
            soda_en = !soda_tc;
            if (soda_tc) begin
               if (nick_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  hop_load = 1'b1;
                  state_d  = NICKEL;
               end
            end
         end
         NICKEL: begin
            hop_en = 1'b1;
            if (bus.hopper_ack_i) begin
               nick_acc = 1'b1;
               nick_d   = nick_dec;
               if (nick_dec == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end else if (hop_tc) begin
               state_d = FAULT;
            end
         end
         GAP: begin
            hop_load = 1'b1;
            state_d  = NICKEL;
         end
         FAULT: begin
            if (bus.fault_clr_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (bus.soda_i && (state_q inside {VEND, NICKEL, GAP})) begin
         if (!pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_code_d = bus.change_i;
         end else begin
            ovf_d = 1'b1;
         end
      end
      if (bus.soda_i && state_q == FAULT) ovf_d = 1'b1;

      // Entering FAULT flushes the slot; a strobe that would have been held there is lost.
      if (state_d == FAULT && state_q != FAULT) begin
         pend_vld_d = 1'b0;
         if (bus.soda_i && !(state_q == IDLE && !pend_vld_q)) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         nick_q      <= '0;
         pend_vld_q  <= 1'b0;
         pend_code_q <= '0;
         ovf_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         nick_q      <= nick_d;
         pend_vld_q  <= pend_vld_d;
         pend_code_q <= pend_code_d;
         ovf_q       <= ovf_d;
         done_q      <= done_d;
      end
   end

   assign bus.soda_sol_o     = (state_q == VEND);
   assign bus.hopper_req_o   = (state_q == NICKEL);
   assign bus.busy_o         = (state_q != IDLE);
   assign bus.fault_o        = (state_q == FAULT);
   assign bus.done_o         = done_q;
   assign bus.overflow_o     = ovf_q;
   assign bus.nickels_left_o = nick_q;

`ifdef VEND_DISPENSER_STATS_EN
   logic [15:0] vend_cnt_q, nick_cnt_q;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         vend_cnt_q <= '0;
         nick_cnt_q <= '0;
      end else begin
         if (done_d && vend_cnt_q != 16'hFFFF)   vend_cnt_q <= vend_cnt_q + 16'd1;
         if (nick_acc && nick_cnt_q != 16'hFFFF) nick_cnt_q <= nick_cnt_q + 16'd1;
      end
   end

   assign bus.vend_count_o   = vend_cnt_q;
   assign bus.nickel_count_o = nick_cnt_q;
`endif
endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench for vend_dispenser: expected vends queued at strobe time, checked on done_o.
module tb_vend_dispenser;
   localparam int SODA_PULSE_CYC     = 4;
   localparam int NICKEL_TIMEOUT_CYC = 16;
   localparam int ACK_DLY            = 2;

   logic clk_i;
   logic reset_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_q[$];
   bit   ack_en   = 1'b1;

   vend_dispenser_if bus();

   vend_dispenser #(
      .SODA_PULSE_CYC     (SODA_PULSE_CYC),
      .NICKEL_TIMEOUT_CYC (NICKEL_TIMEOUT_CYC)
   ) dut (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Hopper model: acks once a request has been held ACK_DLY cycles.
   int req_age = 0;
   always @(negedge clk_i) begin
      if (bus.hopper_req_o) req_age++;
      else                  req_age = 0;
      bus.hopper_ack_i = ack_en && bus.hopper_req_o && (req_age == ACK_DLY);
   end

   // Monitor: per-vend pulse length, request count, gap width and remaining-nickel sequence.
   bit soda_prev = 0, req_prev = 0, done_prev = 0;
   int soda_len = 0, last_soda_len = 0, req_pulses = 0, low_run = 0;
   always @(negedge clk_i) begin
      if (!reset_n) begin
         soda_prev = 0; req_prev = 0; done_prev = 0;
         soda_len = 0; req_pulses = 0; low_run = 0;
      end else begin
         if (bus.soda_sol_o) begin
            if (!soda_prev) begin
               soda_len   = 0;
               req_pulses = 0;
            end
            soda_len++;
         end else if (soda_prev) begin
            last_soda_len = soda_len;
         end
         if (bus.hopper_req_o && !req_prev) begin
            if (exp_q.size() > 0) begin
               check_eq("left_at_req", 32'(bus.nickels_left_o), 32'(exp_q[0] - req_pulses));
               if (req_pulses > 0) check_eq("gap_len", low_run, 1);
            end
            req_pulses++;
         end
         low_run = bus.hopper_req_o ? 0 : low_run + 1;
         if (bus.done_o) begin
            check_eq("done_width", 32'(done_prev), 0);
            if (exp_q.size() == 0) begin
               check_eq("done_unexpected", 1, 0);
            end else begin
               int e;
               e = exp_q.pop_front();
               check_eq("done_nickels", req_pulses, e);
               check_eq("done_pulse_len", last_soda_len, SODA_PULSE_CYC);
               check_eq("done_left", 32'(bus.nickels_left_o), 0);
            end
         end
         soda_prev = bus.soda_sol_o;
         req_prev  = bus.hopper_req_o;
         done_prev = bus.done_o;
      end
   end

   task automatic strobe(input int code);
      bus.soda_i   = 1'b1;
      bus.change_i = 3'(code);
      @(negedge clk_i);
      bus.soda_i   = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max_cyc);
      bit ok = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk_i);
         if (!bus.busy_o && exp_q.size() == 0) begin
            ok = 1;
            break;
         end
      end
      check_eq(tag, 32'(ok), 1);
   endtask

   initial begin
      int  cnt;
      bit  seen;
      reset_n         = 1'b0;
      bus.soda_i      = 1'b0;
      bus.change_i    = '0;
      bus.fault_clr_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_eq("rst_outputs",
               32'({bus.soda_sol_o, bus.hopper_req_o, bus.busy_o, bus.done_o,
                    bus.fault_o, bus.overflow_o, bus.nickels_left_o}), 0);
      reset_n = 1'b1;
      @(negedge clk_i);

      // No change: solenoid only.
      exp_q.push_back(0);
      strobe(0);
      check_eq("soda_latency", 32'(bus.soda_sol_o), 1);
      wait_idle("idle_after_c0", 20);
      check_eq("busy_after_c0", 32'(bus.busy_o), 0);

      // Three nickels with a responsive hopper.
      exp_q.push_back(3);
      strobe(3);
      wait_idle("idle_after_c3", 60);

      // Dead hopper: timeout, clear, then a normal vend.
      ack_en = 1'b0;
      strobe(2);
      cnt = 0;
      while (!bus.hopper_req_o && cnt < 20) begin
         @(negedge clk_i);
         cnt++;
      end
      cnt = 0;
      while (bus.hopper_req_o && cnt < 40) begin
         @(negedge clk_i);
         cnt++;
      end
      check_eq("req_len_timeout", cnt, NICKEL_TIMEOUT_CYC);
      check_eq("fault_set", 32'(bus.fault_o), 1);
      check_eq("fault_left_hold", 32'(bus.nickels_left_o), 2);
      check_eq("fault_sol_off", 32'(bus.soda_sol_o), 0);
      bus.fault_clr_i = 1'b1;
      @(negedge clk_i);
      bus.fault_clr_i = 1'b0;
      check_eq("fault_cleared", 32'({bus.fault_o, bus.busy_o}), 0);
      ack_en = 1'b1;
      exp_q.push_back(1);
      strobe(1);
      wait_idle("idle_after_recover", 60);

      // Back-to-back strobes: 1 served, 4 held, 2 dropped.
      exp_q.push_back(1);
      strobe(1);
      exp_q.push_back(4);
      strobe(4);
      strobe(2);
      @(negedge clk_i);
      check_eq("overflow_set", 32'(bus.overflow_o), 1);
      wait_idle("idle_after_pending", 120);
      check_eq("overflow_sticky", 32'(bus.overflow_o), 1);

      // Illegal code: straight to FAULT, no solenoid.
      strobe(6);
      check_eq("bad_code_fault", 32'(bus.fault_o), 1);
      seen = bus.soda_sol_o;
      repeat (3) begin
         @(negedge clk_i);
         seen |= bus.soda_sol_o;
      end
      check_eq("bad_code_no_sol", 32'(seen), 0);
      bus.fault_clr_i = 1'b1;
      @(negedge clk_i);
      bus.fault_clr_i = 1'b0;
      check_eq("clr_overflow", 32'({bus.overflow_o, bus.fault_o}), 0);

      // Async reset in the middle of dispensing, with a request pending.
      exp_q.push_back(3);
      strobe(3);
      exp_q.push_back(2);
      strobe(2);
      cnt = 0;
      while (!(bus.hopper_req_o && bus.nickels_left_o == 3'd2) && cnt < 40) begin
         @(negedge clk_i);
         cnt++;
      end
      check_eq("reached_mid_nickel", 32'(cnt < 40), 1);
`ifdef VEND_DISPENSER_STATS_EN
      check_eq("vend_count", 32'(bus.vend_count_o), 5);
      check_eq("nickel_count", 32'(bus.nickel_count_o), 10);
`endif
      #2 reset_n = 1'b0;
      #1;
      check_eq("async_rst_outputs",
               32'({bus.soda_sol_o, bus.hopper_req_o, bus.busy_o, bus.done_o,
                    bus.fault_o, bus.overflow_o, bus.nickels_left_o}), 0);
`ifdef VEND_DISPENSER_STATS_EN
      check_eq("rst_counters", 32'({bus.vend_count_o, bus.nickel_count_o}), 0);
`endif
      exp_q.delete();
      @(negedge clk_i);
      reset_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk_i);
         seen |= bus.busy_o;
      end
      check_eq("pending_cleared", 32'(seen), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream of the coin-counting vending FSM: consumes its one-cycle soda strobe and 3-bit change code (units of 5 cents, legal 0-4).
- Drives the soda solenoid for a fixed pulse, then dispenses change one nickel at a time through a req/ack handshake with the coin hopper.
- Holds one pending request so back-to-back vends are not lost. Flags hopper timeouts and dropped requests.

Parameters:
- SODA_PULSE_CYC, 4, cycles soda_sol_o is held high per vend (>=1).
- NICKEL_TIMEOUT_CYC, 16, max cycles hopper_req_o may wait for hopper_ack_i before fault (>=2).

Ports:
- clk_i  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- soda_i  in  1  one-cycle vend strobe from vending FSM
- change_i  in  3  nickels owed, sampled in the cycle soda_i=1
- hopper_ack_i  in  1  hopper has ejected one nickel (level or pulse)
- fault_clr_i  in  1  clears FAULT state and overflow_o
- soda_sol_o  out  1  soda solenoid drive
- hopper_req_o  out  1  request one nickel
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle pulse on successful completion of a vend
- fault_o  out  1  high in FAULT
- overflow_o  out  1  sticky: a vend request was dropped
- nickels_left_o  out  3  nickels still owed for the active vend

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0. Pending slot empty. Counters 0.
- States: IDLE, VEND, NICKEL, GAP, FAULT. All outputs are registered from the state and counters.
- IDLE:
  - Source priority: pending slot first, then soda_i.
  - If a source is present and its code is 0-4: load nickels_left=code, load timer=SODA_PULSE_CYC-1, go to VEND.
  - If the code is 5-7: go to FAULT; no vend is performed.
- Latency: soda_i at edge N -> soda_sol_o=1 from N+1 for exactly SODA_PULSE_CYC cycles.
- VEND:
  - soda_sol_o=1.
  - When the timer reaches 0: if nickels_left=0, go to IDLE and pulse done_o in the first IDLE cycle.
  - Otherwise go to NICKEL with timer=0.
- NICKEL:
  - hopper_req_o=1; the timer counts up.
  - On hopper_ack_i=1: decrement nickels_left.
    - New value 0 -> IDLE plus done_o pulse.
    - Otherwise -> GAP.
  - If the timer reaches NICKEL_TIMEOUT_CYC-1 with no ack: go to FAULT.
  - An ack in the same cycle as the timeout wins over the timeout.
- GAP: exactly one cycle with hopper_req_o=0 so each nickel is a separate request; then NICKEL with timer cleared.
- FAULT:
  - fault_o=1; soda_sol_o=0; hopper_req_o=0; nickels_left_o holds its value.
  - The pending slot is flushed on entry.
  - fault_clr_i=1 -> IDLE next cycle and overflow_o is cleared.
- Pending slot:
  - In VEND, NICKEL or GAP, soda_i with the slot empty captures change_i.
  - soda_i with the slot full drops the request and sets overflow_o.
  - soda_i in FAULT is dropped and sets overflow_o.
  - In IDLE, when the slot is consumed and soda_i arrives in the same cycle, soda_i refills the slot; no drop.
- hopper_ack_i outside NICKEL is ignored.
- Widths: nickels_left is 3 bits. Timers are sized with $clog2 of the larger parameter, plus 1.

Optional Feature:
- Macro VEND_DISPENSER_STATS_EN.
- Defined:
  - Adds output vend_count_o [15:0], incremented on each done_o.
  - Adds output nickel_count_o [15:0], incremented on each accepted hopper_ack_i.
  - Both saturate at 16'hFFFF, reset to 0, and are unaffected by fault_clr_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - state typedef enum logic [2:0] {IDLE, VEND, NICKEL, GAP, FAULT}
  - localparam MAX_NICKELS=4
  - localparam CHANGE_W=3
- The vending FSM also imports CHANGE_W from this package.
- Natural sub-module: vend_timer, a loadable up/down cycle counter with a terminal-count flag. It is instantiated twice, once for the soda pulse and once for the hopper timeout.

Test Plan:
- soda_i with change_i=0 -> soda_sol_o high 4 cycles; no hopper_req_o; done_o pulse 1 cycle later; busy_o low after.
- change_i=3, hopper ack 2 cycles after each req -> 3 distinct hopper_req_o pulses separated by 1-cycle GAP; nickels_left_o 3->2->1->0; done_o once.
- change_i=2, hopper never acks -> hopper_req_o high 16 cycles then fault_o=1; fault_clr_i -> IDLE; a fresh soda_i vends normally.
- Three soda_i strobes (change 1, 4, 2) during one active vend -> first is served; change 4 is held pending and served next; change 2 is dropped and overflow_o=1.
- change_i=6 -> immediate FAULT; soda_sol_o never asserted.
- reset_n low mid-NICKEL -> all outputs 0 immediately (async) and pending cleared; with VEND_DISPENSER_STATS_EN, counters read 0.
